// File: rtl/dec2bin_iter_if.sv
// Operand/result handshake bundle for the BCD-to-binary converter.
// The master side supplies operands and consumes results; the slave side is the converter.
interface dec2bin_iter_if #(
  parameter int unsigned NumDigits   = 3,
  parameter int unsigned DigitWidth  = 4,
  parameter int unsigned ResultWidth = 16
) ();
  logic                              in_valid;
  logic                              in_ready;
  logic [NumDigits*DigitWidth-1:0]   digits;
  logic                              digit_sign;
  logic                              out_valid;
  logic                              out_ready;
  logic [ResultWidth-1:0]            unsign_dec;
  logic [ResultWidth-1:0]            signed_dec;
  logic                              overflow;
  logic                              digit_err;

  modport master (
    output in_valid, digits, digit_sign, out_ready,
    input  in_ready, out_valid, unsign_dec, signed_dec, overflow, digit_err
  );

  modport slave (
    input  in_valid, digits, digit_sign, out_ready,
    output in_ready, out_valid, unsign_dec, signed_dec, overflow, digit_err
  );
endinterface

// File: rtl/dec2bin_iter.sv
// Sequential BCD-to-binary converter: one x10+d step per cycle, MSD first, then an
// optional two's-complement negation. Results leave over a valid/ready handshake with
// sticky overflow and bad-digit flags attached.
module dec2bin_iter #(
  parameter int unsigned NumDigits   = 3,
  parameter int unsigned DigitWidth  = 4,
  parameter int unsigned ResultWidth = 16
) (
  input logic           clk_i,
  input logic           rst_ni,
  dec2bin_iter_if.slave bus
);

  localparam int unsigned IdxWidth  = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam int unsigned WideWidth = ResultWidth + 4;

  localparam logic [IdxWidth-1:0]    LastIdx  = IdxWidth'(NumDigits - 1);
  localparam logic [DigitWidth-1:0]  MaxDigit = DigitWidth'(9);
  // Largest magnitudes representable as positive / negative signed results.
  localparam logic [ResultWidth-1:0] MaxPos   = {1'b0, {(ResultWidth-1){1'b1}}};
  localparam logic [ResultWidth-1:0] MaxNeg   = {1'b1, {(ResultWidth-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StConv, StNeg, StDone} state_e;

  state_e                          state_q;
  logic [NumDigits*DigitWidth-1:0] digits_q;
  logic                            sign_q;
  logic [ResultWidth-1:0]          acc_q;
  logic [IdxWidth-1:0]             idx_q;
  logic [ResultWidth-1:0]          unsign_q;
  logic [ResultWidth-1:0]          signed_q;
  logic                            overflow_q;
  logic                            digit_err_q;

  logic [DigitWidth-1:0]           cur_digit;
  logic [WideWidth-1:0]            step_wide;

  // Select the digit under the index and form acc*10 + digit with headroom for overflow.
  always_comb begin
    cur_digit = digits_q[idx_q*DigitWidth +: DigitWidth];
    step_wide = (WideWidth'(acc_q) << 3) + (WideWidth'(acc_q) << 1) + WideWidth'(cur_digit);
  end

  // Control FSM with the datapath and registered result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      digits_q    <= '0;
      sign_q      <= 1'b0;
      acc_q       <= '0;
      idx_q       <= '0;
      unsign_q    <= '0;
      signed_q    <= '0;
      overflow_q  <= 1'b0;
      digit_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            digits_q    <= bus.digits;
            sign_q      <= bus.digit_sign;
            acc_q       <= '0;
            idx_q       <= LastIdx;
            overflow_q  <= 1'b0;
            digit_err_q <= 1'b0;
            state_q     <= StConv;
          end
        end
        StConv: begin
          acc_q <= step_wide[ResultWidth-1:0];
          if (|step_wide[WideWidth-1:ResultWidth]) overflow_q <= 1'b1;
          // Out-of-range digits are flagged but still folded in at face value.
          if (cur_digit > MaxDigit) digit_err_q <= 1'b1;
          if (idx_q == '0) begin
            state_q <= StNeg;
          end else begin
            idx_q <= idx_q - IdxWidth'(1);
          end
        end
        StNeg: begin
          unsign_q <= acc_q;
          signed_q <= sign_q ? (~acc_q + ResultWidth'(1)) : acc_q;
          if ((!sign_q && (acc_q > MaxPos)) || (sign_q && (acc_q > MaxNeg))) begin
            overflow_q <= 1'b1;
          end
          state_q <= StDone;
        end
        StDone: begin
          if (bus.out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.unsign_dec = unsign_q;
  assign bus.signed_dec = signed_q;
  assign bus.overflow   = overflow_q;
  assign bus.digit_err  = digit_err_q;

endmodule

// File: tb/tb_dec2bin_iter.sv
// Directed bench for dec2bin_iter: a 3-digit and a 5-digit instance, expected results
// queued when an operand is sent and compared when the converter presents its result.
module tb_dec2bin_iter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec2bin_iter_if #(.NumDigits(3), .DigitWidth(4), .ResultWidth(16)) bus3 ();
  dec2bin_iter_if #(.NumDigits(5), .DigitWidth(4), .ResultWidth(16)) bus5 ();

  dec2bin_iter #(.NumDigits(3), .DigitWidth(4), .ResultWidth(16)) u_dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus3.slave)
  );

  dec2bin_iter #(.NumDigits(5), .DigitWidth(4), .ResultWidth(16)) u_dut5 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus5.slave)
  );

  typedef struct packed {
    logic [15:0] u;
    logic [15:0] s;
    logic        ovf;
    logic        derr;
  } exp_t;

  exp_t sb3[$];
  exp_t sb5[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact decimal value, reduced mod 2^16, with range checks on the signed result.
  function automatic exp_t model(input int nd, input logic [19:0] dg, input logic s);
    exp_t        e;
    longint      full;
    logic [3:0]  d;
    e    = '0;
    full = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      d    = dg[i*4 +: 4];
      full = full * 10 + longint'(d);
      if (d > 4'd9) e.derr = 1'b1;
    end
    e.u   = full[15:0];
    e.s   = s ? (16'd0 - e.u) : e.u;
    e.ovf = (full >= 65536) || (!s && full > 32767) || (s && full > 32768);
    return e;
  endfunction

  task automatic run3(input logic [11:0] dg, input logic s, input int stall);
    exp_t e;
    int   n;
    sb3.push_back(model(3, {8'h00, dg}, s));
    for (int k = 0; k < 50 && !bus3.in_ready; k++) begin
      @(posedge clk); #1;
    end
    check("in_ready3", {31'd0, bus3.in_ready}, 32'd1);
    bus3.digits     = dg;
    bus3.digit_sign = s;
    bus3.in_valid   = 1'b1;
    bus3.out_ready  = (stall == 0);
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    n = 0;
    while (!bus3.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency3", n, 32'd4);
    e = sb3.pop_front();
    check("unsign3", {16'd0, bus3.unsign_dec}, {16'd0, e.u});
    check("signed3", {16'd0, bus3.signed_dec}, {16'd0, e.s});
    check("ovf3", {31'd0, bus3.overflow}, {31'd0, e.ovf});
    check("derr3", {31'd0, bus3.digit_err}, {31'd0, e.derr});
    if (stall > 0) begin
      // Offer a new operand that must be ignored while the result is stalled.
      bus3.digits     = 12'h111;
      bus3.digit_sign = 1'b0;
      bus3.in_valid   = 1'b1;
      for (int c = 0; c < stall; c++) begin
        @(posedge clk); #1;
        check("stall_valid", {31'd0, bus3.out_valid}, 32'd1);
        check("stall_ready", {31'd0, bus3.in_ready}, 32'd0);
        check("stall_unsign", {16'd0, bus3.unsign_dec}, {16'd0, e.u});
        check("stall_signed", {16'd0, bus3.signed_dec}, {16'd0, e.s});
      end
      bus3.in_valid  = 1'b0;
      bus3.out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_valid", {31'd0, bus3.out_valid}, 32'd0);
      check("release_ready", {31'd0, bus3.in_ready}, 32'd1);
    end
  endtask

  task automatic run5(input logic [19:0] dg, input logic s);
    exp_t e;
    int   n;
    sb5.push_back(model(5, dg, s));
    for (int k = 0; k < 50 && !bus5.in_ready; k++) begin
      @(posedge clk); #1;
    end
    check("in_ready5", {31'd0, bus5.in_ready}, 32'd1);
    bus5.digits     = dg;
    bus5.digit_sign = s;
    bus5.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    n = 0;
    while (!bus5.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency5", n, 32'd6);
    e = sb5.pop_front();
    check("unsign5", {16'd0, bus5.unsign_dec}, {16'd0, e.u});
    check("signed5", {16'd0, bus5.signed_dec}, {16'd0, e.s});
    check("ovf5", {31'd0, bus5.overflow}, {31'd0, e.ovf});
  endtask

  initial begin
    bus3.in_valid = 1'b0; bus3.digits = '0; bus3.digit_sign = 1'b0; bus3.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.digits = '0; bus5.digit_sign = 1'b0; bus5.out_ready = 1'b1;

    // Reset state.
    #2;
    check("rst_in_ready", {31'd0, bus3.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus3.out_valid}, 32'd0);
    check("rst_unsign", {16'd0, bus3.unsign_dec}, 32'd0);
    check("rst_flags", {30'd0, bus3.overflow, bus3.digit_err}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run3(12'h123, 1'b0, 0);
    check("val_123", {16'd0, bus3.signed_dec}, 32'h007B);
    run3(12'h999, 1'b1, 0);
    check("val_m999", {16'd0, bus3.signed_dec}, 32'hFC19);
    run3(12'h000, 1'b1, 0);
    check("val_m0", {16'd0, bus3.signed_dec}, 32'h0000);
    run3(12'h1A3, 1'b0, 0);
    check("val_1A3", {16'd0, bus3.unsign_dec}, 32'd203);
    run3(12'h042, 1'b0, 0);
    check("derr_clear", {31'd0, bus3.digit_err}, 32'd0);
    run3(12'h456, 1'b1, 10);

    run5(20'h32768, 1'b1);
    check("val_m32768", {16'd0, bus5.signed_dec}, 32'h8000);
    run5(20'h32768, 1'b0);
    check("ovf_32768", {31'd0, bus5.overflow}, 32'd1);
    run5(20'h99999, 1'b0);
    check("val_99999", {16'd0, bus5.unsign_dec}, 32'h869F);

    // Reset in the middle of a conversion, between clock edges.
    for (int k = 0; k < 50 && !bus3.in_ready; k++) begin
      @(posedge clk); #1;
    end
    bus3.digits = 12'h987; bus3.digit_sign = 1'b1; bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, bus3.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus3.out_valid}, 32'd0);
    check("abort_unsign", {16'd0, bus3.unsign_dec}, 32'd0);
    check("abort_signed", {16'd0, bus3.signed_dec}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run3(12'h789, 1'b0, 0);
    check("val_789", {16'd0, bus3.unsign_dec}, 32'd789);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
